pattern_detector_param: RTL and testbench

Parametrised Moore sequence detector. Matches a serial bit stream against a programmable pattern of `PAT_W` bits, in overlapping or non-overlapping mode, and counts matches in a saturating counter. It supersedes the fixed-pattern `1010` detectors in the design. It sits directly on a serial data line, gated by a sample enable.

---
 rtl/pattern_detector_param.sv | 87 ++++++++
 tb/tb_pattern_detector_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : pattern_detector_param
// Description : Moore serial pattern detector with a programmable PAT_W-bit
//               pattern, overlapping / non-overlapping matching and a
//               saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr,
    output logic             q,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    // fill counts 0..PAT_W, so it needs room for the value PAT_W itself
    localparam int              FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  win_q;
    logic [PAT_W-1:0]  win_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0]  pat_q;
    logic              q_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              hit;

    // Next history window, saturating fill and hit decision for an enabled edge
    always_comb begin
        win_d    = {win_q[PAT_W-2:0], in};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit      = (fill_inc == FILL_FULL) && (win_d == pat_q);
        // A non-overlapping hit consumes the whole window, so priming restarts
        fill_d   = (hit && !overlap) ? '0 : fill_inc;
        // Counter sticks at its maximum instead of wrapping
        cnt_d    = (hit && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Detector state: load has priority over sampling; clr overrides any increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q  <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            q_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (load) begin
                pat_q  <= pat_in;
                win_q  <= '0;
                fill_q <= '0;
                q_q    <= 1'b0;
            end else if (en) begin
                win_q  <= win_d;
                fill_q <= fill_d;
                q_q    <= hit;
            end

            if (clr) begin
                cnt_q <= '0;
            end else if (en && !load) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign q           = q_q;
    assign match_count = cnt_q;
    assign pattern     = pat_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_detector_param
// Description : Scoreboard bench for pattern_detector_param (PAT_W=4, CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = 7;

    logic             clk;
    logic             reset;
    logic             in;
    logic             en;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             clr;
    logic             q;
    logic [CNT_W-1:0] match_count;
    logic [PAT_W-1:0] pattern;

    pattern_detector_param #(
        .PAT_W  (PAT_W),
        .PATTERN(4'b1010),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .en         (en),
        .overlap    (overlap),
        .load       (load),
        .pat_in     (pat_in),
        .clr        (clr),
        .q          (q),
        .match_count(match_count),
        .pattern    (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       q;
        logic [2:0] cnt;
        logic [3:0] pat;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_win;
    int         m_fill;
    logic [3:0] m_pat;
    logic       m_q;
    int         m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_win  = 4'b0;
        m_fill = 0;
        m_pat  = 4'b1010;
        m_q    = 1'b0;
        m_cnt  = 0;
    endtask

    // Drive one clock of stimulus, push the model's prediction, then compare
    task automatic step(input logic b, input logic e, input logic ov,
                        input logic ld, input logic [3:0] pi, input logic cl,
                        input string tag);
        exp_t x;
        exp_t y;
        int   fn;
        logic h;
        in = b; en = e; overlap = ov; load = ld; pat_in = pi; clr = cl;
        if (ld) begin
            m_pat = pi; m_win = 4'b0; m_fill = 0; m_q = 1'b0;
        end else if (e) begin
            m_win = {m_win[2:0], b};
            fn = (m_fill + 1 > PAT_W) ? PAT_W : m_fill + 1;
            h = (fn == PAT_W) && (m_win == m_pat);
            m_q = h;
            m_fill = (h && !ov) ? 0 : fn;
            if (h && m_cnt < CNT_MAX) m_cnt++;
        end
        if (cl) m_cnt = 0;
        x.q = m_q; x.cnt = m_cnt[2:0]; x.pat = m_pat;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        y = exp_q.pop_front();
        check_eq({tag, ".q"},     {31'b0, q},           {31'b0, y.q});
        check_eq({tag, ".cnt"},   {29'b0, match_count}, {29'b0, y.cnt});
        check_eq({tag, ".pat"},   {28'b0, pattern},     {28'b0, y.pat});
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input logic ov, input string tag);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b0, 4'b0, 1'b0, tag);
    endtask

    // Reload the default pattern to clear history, optionally clearing the count
    task automatic restart(input logic cl);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, cl, "restart");
    endtask

    initial begin
        logic [15:0] pat16;
        model_reset();
        reset = 1'b0; in = 1'b0; en = 1'b1; overlap = 1'b0;
        load = 1'b0; pat_in = 4'b0; clr = 1'b0;

        // 1. Reset with toggling data
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; in = ~in;
        end
        check_eq("rst.q",   {31'b0, q},           32'd0);
        check_eq("rst.cnt", {29'b0, match_count}, 32'd0);
        check_eq("rst.pat", {28'b0, pattern},     32'ha);
        reset = 1'b1;
        feed(16'b101, 3, 1'b1, "prime3");
        check_eq("prime3.nohit", {31'b0, q}, 32'd0);

        // 2. Non-overlapping
        restart(1'b1);
        pat16 = 16'b10101010;
        feed(pat16, 8, 1'b0, "novl");
        check_eq("novl.count", {29'b0, match_count}, 32'd2);

        // 3. Overlapping
        restart(1'b1);
        feed(pat16, 8, 1'b1, "ovl");
        check_eq("ovl.count", {29'b0, match_count}, 32'd3);

        // 4. Enable gating
        restart(1'b1);
        feed(16'b101, 3, 1'b0, "gate.pre");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "gate.off");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, "gate.hit");
        check_eq("gate.hitq", {31'b0, q}, 32'd1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "gate.hold");
        check_eq("gate.holdq", {31'b0, q}, 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, "gate.drop");
        check_eq("gate.dropq", {31'b0, q}, 32'd0);
        check_eq("gate.count", {29'b0, match_count}, 32'd1);

        // 5. Load and clear (count carries 1 from the previous test)
        restart(1'b0);
        feed(16'b101, 3, 1'b0, "ld.pre");
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, "ld.load");
        check_eq("ld.pattern", {28'b0, pattern}, 32'h6);
        feed(16'b1011, 4, 1'b0, "ld.nohit");
        check_eq("ld.nohitq", {31'b0, q}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b1, "ld.hitclr");
        check_eq("ld.hitq",   {31'b0, q},           32'd1);
        check_eq("ld.clrcnt", {29'b0, match_count}, 32'd0);

        // 6. Saturation then asynchronous reset mid-cycle
        restart(1'b1);
        feed(16'b10, 2, 1'b1, "sat.prime");
        for (int r = 0; r < 10; r++) feed(16'b10, 2, 1'b1, "sat");
        check_eq("sat.count", {29'b0, match_count}, 32'd7);
        check_eq("sat.q",     {31'b0, q},           32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst.q",   {31'b0, q},           32'd0);
        check_eq("arst.cnt", {29'b0, match_count}, 32'd0);
        check_eq("arst.pat", {28'b0, pattern},     32'ha);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        feed(16'b1010, 4, 1'b1, "post");
        check_eq("post.q",   {31'b0, q},           32'd1);
        check_eq("post.cnt", {29'b0, match_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
